// File: rtl/iddr_ds_rx.sv
// Differential DDR lane receiver: IBUFDS -> IDDR (same-edge pipelined) -> bit-slip gearbox -> training FSM -> 4-deep FIFO.
// Optional RX_LANE_INVERT_EN adds an inv input that inverts both IDDR bits ahead of the gearbox.
module iddr_ds_rx #(
  parameter string             IOSTANDARD    = "DIFF_SSTL15",
  parameter string             IBUF_LOW_PWR  = "TRUE",
  parameter int                WORD_W        = 8,
  parameter logic [WORD_W-1:0] TRAIN_PATTERN = WORD_W'(8'hA5),
  parameter int                MATCH_CNT     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dq,
  input  logic              ndq,
  input  logic              train,
`ifdef RX_LANE_INVERT_EN
  input  logic              inv,
`endif
  output logic [WORD_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              locked,
  output logic              train_fail,
  output logic              overflow
);

  localparam int HALF   = WORD_W / 2;
  localparam int HIST_W = 2 * WORD_W;
  localparam int SLIP_W = $clog2(WORD_W);
  localparam int PH_W   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int MIS_W  = $clog2(2 * WORD_W + 1);
  localparam int MC_W   = 4;
  localparam int DEPTH  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_LOCKED
  } state_t;

  // Differential input buffer
  logic pad;

  if (IOSTANDARD != "" && (IBUF_LOW_PWR == "TRUE" || IBUF_LOW_PWR == "FALSE")) begin : g_ibufds
    assign pad = dq & ~ndq;
  end else begin : g_ibuf_se
    // Unrecognised buffer attributes: fall back to single-ended P-side sensing.
    assign pad = dq;
  end

  // IDDR: rising and falling samples re-registered together on the next rising edge
  logic rise_s;
  logic fall_s;
  logic q1;
  logic q2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_s <= 1'b0;
    end else begin
      rise_s <= pad;
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      fall_s <= 1'b0;
    end else begin
      fall_s <= pad;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q1 <= 1'b0;
      q2 <= 1'b0;
    end else begin
      q1 <= rise_s;
      q2 <= fall_s;
    end
  end

  logic [1:0] pair;

`ifdef RX_LANE_INVERT_EN
  assign pair = {q2, q1} ^ {2{inv}};
`else
  assign pair = {q2, q1};
`endif

  // Gearbox: newest pair enters at the top so lower history bits are earlier on the wire
  logic [HIST_W-1:0] hist;
  logic [PH_W-1:0]   phase;
  logic [SLIP_W-1:0] slip;
  logic              boundary;
  logic [WORD_W-1:0] cand;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist  <= '0;
      phase <= '0;
    end else begin
      hist  <= {pair, hist[HIST_W-1:2]};
      phase <= (phase == PH_W'(HALF - 1)) ? '0 : phase + 1'b1;
    end
  end

  assign boundary = (phase == PH_W'(HALF - 1));
  assign cand     = hist[slip +: WORD_W];

  // Training / alignment FSM
  state_t            state;
  state_t            state_n;
  logic [SLIP_W-1:0] slip_n;
  logic [MC_W-1:0]   match_cnt;
  logic [MC_W-1:0]   match_n;
  logic [MIS_W-1:0]  mis_cnt;
  logic [MIS_W-1:0]  mis_n;
  logic              fail_n;
  logic              arm;
  logic              arm_n;
  logic              train_q;
  logic              train_rise;
  logic              push;

  assign train_rise = train & ~train_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      slip       <= '0;
      match_cnt  <= '0;
      mis_cnt    <= '0;
      arm        <= 1'b1;
      train_q    <= 1'b0;
      train_fail <= 1'b0;
      locked     <= 1'b0;
    end else begin
      state      <= state_n;
      slip       <= slip_n;
      match_cnt  <= match_n;
      mis_cnt    <= mis_n;
      arm        <= arm_n;
      train_q    <= train;
      train_fail <= fail_n;
      locked     <= (state_n == ST_LOCKED);
    end
  end

  always_comb begin
    state_n = state;
    slip_n  = slip;
    match_n = match_cnt;
    mis_n   = mis_cnt;
    fail_n  = train_fail;
    arm_n   = arm | ~train;
    push    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (boundary && train && arm) begin
          state_n = ST_SEARCH;
          match_n = '0;
          mis_n   = '0;
          fail_n  = 1'b0;
        end
      end
      ST_SEARCH: begin
        if (boundary) begin
          if (cand == TRAIN_PATTERN) begin
            match_n = match_cnt + 1'b1;
            if (match_cnt == MC_W'(MATCH_CNT - 1)) begin
              state_n = ST_LOCKED;
            end
          end else begin
            slip_n  = (slip == SLIP_W'(WORD_W - 1)) ? '0 : slip + 1'b1;
            match_n = '0;
            mis_n   = mis_cnt + 1'b1;
            // Out of slip positions twice over: give up until train is re-armed.
            if (mis_cnt == MIS_W'(2 * WORD_W - 1)) begin
              state_n = ST_IDLE;
              fail_n  = 1'b1;
              arm_n   = ~train;
            end
          end
        end
      end
      ST_LOCKED: begin
        push = boundary;
        if (train_rise) begin
          state_n = ST_SEARCH;
          match_n = '0;
          mis_n   = '0;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Output FIFO: shift-register style so the head entry is the registered dout
  logic [WORD_W-1:0] fdat   [DEPTH];
  logic [WORD_W-1:0] sh_dat [DEPTH];
  logic [WORD_W-1:0] nx_dat [DEPTH];
  logic [DEPTH-1:0]  fvld;
  logic [DEPTH-1:0]  sh_vld;
  logic [DEPTH-1:0]  nx_vld;
  logic              pop;
  logic              placed;
  logic              ovf_n;

  always_comb begin
    pop = fvld[0] & dout_ready;
    for (int i = 0; i < DEPTH; i++) begin
      sh_vld[i] = fvld[i];
      sh_dat[i] = fdat[i];
    end
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        sh_vld[i] = fvld[i+1];
        sh_dat[i] = fdat[i+1];
      end
      sh_vld[DEPTH-1] = 1'b0;
    end
    nx_vld = sh_vld;
    nx_dat = sh_dat;
    placed = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (push && !placed && !sh_vld[i]) begin
        nx_vld[i] = 1'b1;
        nx_dat[i] = cand;
        placed    = 1'b1;
      end
    end
    ovf_n = overflow | (push & sh_vld[DEPTH-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fvld     <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        fdat[i] <= '0;
      end
    end else begin
      fvld     <= nx_vld;
      overflow <= ovf_n;
      for (int i = 0; i < DEPTH; i++) begin
        fdat[i] <= nx_dat[i];
      end
    end
  end

  assign dout       = fdat[0];
  assign dout_valid = fvld[0];

endmodule
